iob_regfile_sp_arb: RTL and testbench
=====================================

IOB_REGFILE_SP_ARB -- requirements
Module: iob_regfile_sp_arb

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 2, giving the register file address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the register file data width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  2  per-requester access request; bit i belongs to requester i.
REQ-006 req_we  input  2  per-requester write enable: 1 means write, 0 means read.
REQ-007 req_lock  input  2  per-requester lock: keeps the grant after this transfer.
REQ-008 req_addr  input  2*ADDR_W  per-requester address; requester i uses slice [i*ADDR_W +: ADDR_W].
REQ-009 req_wdata  input  2*DATA_W  per-requester write data; requester i uses slice [i*DATA_W +: DATA_W].
REQ-010 req_ready  output  2  per-requester grant; a transfer occurs when req_valid[i] and req_ready[i] are both 1 in the same cycle.
REQ-011 rsp_valid  output  2  per-requester read-response strobe.
REQ-012 rsp_data  output  DATA_W  read data, qualified by rsp_valid.
REQ-013 rf_we  output  1  write enable to the single-port register file.
REQ-014 rf_addr  output  ADDR_W  address to the register file.
REQ-015 rf_wdata  output  DATA_W  write data to the register file.
REQ-016 rf_rdata  input  DATA_W  combinational read data from the register file at rf_addr.

Function
REQ-017 The block SHALL perform at most one register file access per cycle; at most one req_ready bit SHALL be 1 in any cycle.
REQ-018 The block SHALL hold a 1-bit round-robin pointer prio and a state machine with states IDLE, LOCK0 and LOCK1.
REQ-019 In IDLE with only requester i valid, the block SHALL grant i; with both valid, it SHALL grant prio; with none valid, req_ready SHALL be 2'b00.
REQ-020 req_ready SHALL be combinational from req_valid, state and prio, so a grant is given in the same cycle as the request (zero-cycle arbitration).
REQ-021 On every transfer by requester g, prio SHALL update to ~g at the next edge.
REQ-022 On a transfer by requester g with req_lock[g]=1, the state SHALL become LOCKg.
REQ-023 In LOCKg, only requester g SHALL be granted, and the other requester SHALL see req_ready=0 regardless of its req_valid.
REQ-024 In LOCKg, a transfer by requester g with req_lock[g]=0 SHALL return the state to IDLE; cycles with req_valid[g]=0 SHALL keep the state at LOCKg.
REQ-025 rf_addr and rf_wdata SHALL be taken from the granted requester's slices, and rf_we SHALL equal req_we[g] when a transfer occurs and 0 otherwise.
REQ-026 When no transfer occurs, rf_addr and rf_wdata SHALL be don't-care and rf_we SHALL be 0.
REQ-027 A read transfer by requester g in cycle N SHALL produce rsp_valid[g]=1 in cycle N+1 only, with rsp_data equal to rf_rdata registered at the end of cycle N.
REQ-028 rsp_data SHALL hold its last value while rsp_valid=2'b00.
REQ-029 Write transfers SHALL produce no response.
REQ-030 Back-to-back transfers SHALL be accepted every cycle, giving a throughput of one access per cycle.
REQ-031 A read in cycle N following a write to the same address in cycle N-1 SHALL return the newly written data, because the register file write lands at edge N-1.

Reset
REQ-032 While rst=1: req_ready=2'b00 and rf_we=0; no transfer SHALL occur.
REQ-033 At the first edge with rst=1: state=IDLE, prio=0, rsp_valid=2'b00, rsp_data=0.
REQ-034 Reset asserted while in LOCKg SHALL release the lock, and any pending response SHALL be discarded.

Verification
REQ-035 Requester 0 writes 0xA5A5A5A5 to address 2, then reads address 2 -> rf_we pulses once; rsp_valid=2'b01 one cycle after the read, with rsp_data=0xA5A5A5A5.
REQ-036 Both requesters hold valid reads for 4 cycles after reset -> grants 0,1,0,1 and rsp_valid 01,10,01,10, each lagging its grant by one cycle.
REQ-037 Requester 1 reads address 3 with lock=1, 3 idle cycles follow, then it writes address 3 with lock=0, while requester 0 is valid throughout -> req_ready[0]=0 until the cycle after the unlocking write.
REQ-038 rst asserted during LOCK0 with both requesters valid -> req_ready=00 while in reset; on the first cycle after reset, requester 0 is granted (prio=0) and the state is IDLE.
REQ-039 Single requester 1 issues continuous reads of addresses 0..3 -> req_ready[1]=1 every cycle and 4 consecutive responses with the matching data.

Source files
------------

// File: rtl/iob_regfile_sp_arb.sv
// Two-requester arbiter in front of a single-port register file.
// Round-robin arbitration with per-requester lock and a one-cycle registered read response.
module iob_regfile_sp_arb #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_we,
    input  logic [1:0]          req_lock,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          req_ready,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rf_we,
    output logic [ADDR_W-1:0]   rf_addr,
    output logic [DATA_W-1:0]   rf_wdata,
    input  logic [DATA_W-1:0]   rf_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_prio;
    logic [1:0]          r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data;

    logic [1:0]          w_grant;
    logic                w_xfer;
    logic                w_g;

    // Grant is purely combinational so a request is served in the cycle it appears.
    always_comb begin
        w_grant = 2'b00;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    if (req_valid == 2'b11)
                        w_grant = r_prio ? 2'b10 : 2'b01;
                    else
                        w_grant = req_valid;
                end
                LOCK0:   w_grant = {1'b0, req_valid[0]};
                LOCK1:   w_grant = {req_valid[1], 1'b0};
                default: w_grant = 2'b00;
            endcase
        end
    end

    assign w_xfer    = |w_grant;
    assign w_g       = w_grant[1];

    assign req_ready = w_grant;
    assign rf_we     = w_xfer & req_we[w_g];
    assign rf_addr   = w_g ? req_addr[ADDR_W +: ADDR_W]  : req_addr[0 +: ADDR_W];
    assign rf_wdata  = w_g ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_prio      <= 1'b0;
            r_rsp_valid <= 2'b00;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= 2'b00;
            if (w_xfer) begin
                r_prio <= ~w_g;
                if (!req_we[w_g]) begin
                    r_rsp_valid <= w_grant;
                    r_rsp_data  <= rf_rdata;
                end
                // A transfer without lock always releases back to IDLE.
                if (req_lock[w_g])
                    r_state <= w_g ? LOCK1 : LOCK0;
                else
                    r_state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_iob_regfile_sp_arb.sv
// Testbench for iob_regfile_sp_arb: directed vector table followed by random traffic
// compared against a transaction-level model of the arbiter and register file.
module tb_iob_regfile_sp_arb;

    localparam int AW = 2;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        reqValid = '0;
    logic [1:0]        reqWe = '0;
    logic [1:0]        reqLock = '0;
    logic [2*AW-1:0]   reqAddr = '0;
    logic [2*DW-1:0]   reqWdata = '0;
    logic [1:0]        reqReady;
    logic [1:0]        rspValid;
    logic [DW-1:0]     rspData;
    logic              rfWe;
    logic [AW-1:0]     rfAddr;
    logic [DW-1:0]     rfWdata;
    logic [DW-1:0]     rfRdata;

    logic [DW-1:0]     mem [4];
    logic [DW-1:0]     modelMem [4];

    int                lockOwner;
    int                prio;
    logic [1:0]        mRspValid;
    logic [DW-1:0]     mRspData;
    int                checks = 0;
    int                errors = 0;

    typedef struct {
        logic          r;
        logic [1:0]    v;
        logic [1:0]    we;
        logic [1:0]    lk;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [1:0]    eReady;
        logic          eWe;
        logic [1:0]    eRspV;
        logic [DW-1:0] eRspD;
    } vec_t;

    vec_t vecs[$];

    iob_regfile_sp_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (reqValid),
        .req_we    (reqWe),
        .req_lock  (reqLock),
        .req_addr  (reqAddr),
        .req_wdata (reqWdata),
        .req_ready (reqReady),
        .rsp_valid (rspValid),
        .rsp_data  (rspData),
        .rf_we     (rfWe),
        .rf_addr   (rfAddr),
        .rf_wdata  (rfWdata),
        .rf_rdata  (rfRdata)
    );

    always #5 clk = ~clk;

    // Register file: combinational read, write lands at the clock edge.
    assign rfRdata = mem[rfAddr];
    always @(posedge clk) if (rfWe) mem[rfAddr] <= rfWdata;

    task automatic applyStimulus(input logic r, input logic [1:0] v, input logic [1:0] we,
                                 input logic [1:0] lk, input logic [AW-1:0] a0,
                                 input logic [AW-1:0] a1, input logic [DW-1:0] d0,
                                 input logic [DW-1:0] d1);
        @(negedge clk);
        rst      = r;
        reqValid = v;
        reqWe    = we;
        reqLock  = lk;
        reqAddr  = {a1, a0};
        reqWdata = {d1, d0};
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [DW-1:0] act,
                               input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model of the arbitration rules: compare this cycle, then advance to the next edge.
    task automatic modelCheckAndStep();
        logic [1:0] eReady;
        int         g;
        if (rst)
            eReady = 2'b00;
        else if (lockOwner >= 0)
            eReady = reqValid[lockOwner] ? ((lockOwner == 1) ? 2'b10 : 2'b01) : 2'b00;
        else if (reqValid == 2'b11)
            eReady = (prio == 1) ? 2'b10 : 2'b01;
        else
            eReady = reqValid;
        g = eReady[1] ? 1 : 0;

        checkOutput("model_ready", {30'd0, reqReady}, {30'd0, eReady});
        checkOutput("model_onehot", {31'd0, ($countones(reqReady) <= 1)}, 32'd1);
        checkOutput("model_rf_we", {31'd0, rfWe}, {31'd0, (eReady != 0) && reqWe[g]});
        checkOutput("model_rsp_valid", {30'd0, rspValid}, {30'd0, mRspValid});
        checkOutput("model_rsp_data", rspData, mRspData);
        if (eReady != 0) begin
            checkOutput("model_rf_addr", {30'd0, rfAddr}, {30'd0, reqAddr[g*AW +: AW]});
            checkOutput("model_rf_wdata", rfWdata, reqWdata[g*DW +: DW]);
        end

        if (rst) begin
            lockOwner = -1;
            prio      = 0;
            mRspValid = 2'b00;
            mRspData  = '0;
        end else begin
            mRspValid = 2'b00;
            if (eReady != 0) begin
                prio = 1 - g;
                if (!reqWe[g]) begin
                    mRspValid = eReady;
                    mRspData  = modelMem[reqAddr[g*AW +: AW]];
                end else begin
                    modelMem[reqAddr[g*AW +: AW]] = reqWdata[g*DW +: DW];
                end
                lockOwner = reqLock[g] ? g : -1;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            mem[i]      = 32'h1000_0000 + i;
            modelMem[i] = 32'h1000_0000 + i;
        end
        lockOwner = -1;
        prio      = 0;
        mRspValid = 2'b00;
        mRspData  = '0;

        // r, v, we, lk, a0, a1, d0, d1, eReady, eWe, eRspV, eRspD
        // Write then read-back through requester 0.
        vecs.push_back(vec_t'{1, 2'b11, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b00, 32'h0});
        vecs.push_back(vec_t'{0, 2'b01, 2'b01, 2'b00, 2, 0, 32'hA5A5A5A5, 0, 2'b01, 1, 2'b00, 32'h0});
        vecs.push_back(vec_t'{0, 2'b01, 2'b00, 2'b00, 2, 0, 0, 0, 2'b01, 0, 2'b00, 32'h0});
        vecs.push_back(vec_t'{0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b01, 32'hA5A5A5A5});
        vecs.push_back(vec_t'{0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b00, 32'hA5A5A5A5});
        // Both requesters reading after reset alternate 0,1,0,1.
        vecs.push_back(vec_t'{1, 2'b11, 2'b00, 2'b00, 0, 1, 0, 0, 2'b00, 0, 2'b00, 32'hA5A5A5A5});
        vecs.push_back(vec_t'{0, 2'b11, 2'b00, 2'b00, 0, 1, 0, 0, 2'b01, 0, 2'b00, 32'h0});
        vecs.push_back(vec_t'{0, 2'b11, 2'b00, 2'b00, 0, 1, 0, 0, 2'b10, 0, 2'b01, 32'h1000_0000});
        vecs.push_back(vec_t'{0, 2'b11, 2'b00, 2'b00, 0, 1, 0, 0, 2'b01, 0, 2'b10, 32'h1000_0001});
        vecs.push_back(vec_t'{0, 2'b11, 2'b00, 2'b00, 0, 1, 0, 0, 2'b10, 0, 2'b01, 32'h1000_0000});
        // Requester 1 locks, idles 3 cycles, then unlocks with a write.
        vecs.push_back(vec_t'{0, 2'b10, 2'b00, 2'b10, 0, 3, 0, 0, 2'b10, 0, 2'b10, 32'h1000_0001});
        vecs.push_back(vec_t'{0, 2'b01, 2'b00, 2'b00, 1, 3, 0, 0, 2'b00, 0, 2'b10, 32'h1000_0003});
        vecs.push_back(vec_t'{0, 2'b01, 2'b00, 2'b00, 1, 3, 0, 0, 2'b00, 0, 2'b00, 32'h1000_0003});
        vecs.push_back(vec_t'{0, 2'b01, 2'b00, 2'b00, 1, 3, 0, 0, 2'b00, 0, 2'b00, 32'h1000_0003});
        vecs.push_back(vec_t'{0, 2'b11, 2'b10, 2'b00, 1, 3, 0, 32'hDEADBEEF, 2'b10, 1, 2'b00, 32'h1000_0003});
        vecs.push_back(vec_t'{0, 2'b01, 2'b00, 2'b00, 3, 0, 0, 0, 2'b01, 0, 2'b00, 32'h1000_0003});
        vecs.push_back(vec_t'{0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b01, 32'hDEADBEEF});
        // Reset while requester 0 holds the lock.
        vecs.push_back(vec_t'{0, 2'b01, 2'b00, 2'b01, 0, 0, 0, 0, 2'b01, 0, 2'b00, 32'hDEADBEEF});
        vecs.push_back(vec_t'{0, 2'b11, 2'b00, 2'b01, 0, 0, 0, 0, 2'b01, 0, 2'b01, 32'h1000_0000});
        vecs.push_back(vec_t'{1, 2'b11, 2'b00, 2'b01, 0, 0, 0, 0, 2'b00, 0, 2'b01, 32'h1000_0000});
        vecs.push_back(vec_t'{0, 2'b11, 2'b00, 2'b00, 1, 2, 0, 0, 2'b01, 0, 2'b00, 32'h0});
        vecs.push_back(vec_t'{0, 2'b11, 2'b00, 2'b00, 1, 2, 0, 0, 2'b10, 0, 2'b01, 32'h1000_0001});
        // Requester 1 alone streams reads of addresses 0..3.
        vecs.push_back(vec_t'{0, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 2'b10, 0, 2'b10, 32'hA5A5A5A5});
        vecs.push_back(vec_t'{0, 2'b10, 2'b00, 2'b00, 0, 1, 0, 0, 2'b10, 0, 2'b10, 32'h1000_0000});
        vecs.push_back(vec_t'{0, 2'b10, 2'b00, 2'b00, 0, 2, 0, 0, 2'b10, 0, 2'b10, 32'h1000_0001});
        vecs.push_back(vec_t'{0, 2'b10, 2'b00, 2'b00, 0, 3, 0, 0, 2'b10, 0, 2'b10, 32'hA5A5A5A5});
        vecs.push_back(vec_t'{0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b10, 32'hDEADBEEF});

        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].r, vecs[i].v, vecs[i].we, vecs[i].lk,
                          vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
            checkOutput($sformatf("vec%0d_ready", i), {30'd0, reqReady}, {30'd0, vecs[i].eReady});
            checkOutput($sformatf("vec%0d_rf_we", i), {31'd0, rfWe}, {31'd0, vecs[i].eWe});
            checkOutput($sformatf("vec%0d_rsp_valid", i), {30'd0, rspValid}, {30'd0, vecs[i].eRspV});
            checkOutput($sformatf("vec%0d_rsp_data", i), rspData, vecs[i].eRspD);
            modelCheckAndStep();
        end

        for (int n = 0; n < 400; n++) begin
            logic [1:0] lk;
            lk = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            applyStimulus(($urandom_range(0, 31) == 0), 2'($urandom), 2'($urandom), lk,
                          AW'($urandom), AW'($urandom), $urandom, $urandom);
            modelCheckAndStep();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
